aes_dec_sequencer: RTL
======================

# aes_dec_sequencer

Control block for AES-128 decryption: sequences one shared inverse-round datapath through the 11 round-key applications of a block, fetching each round key from the key-schedule store. It keeps a tag of the last expanded key and triggers key expansion only when the key changes, so back-to-back blocks under one key skip the key-schedule latency. It sits between the host start/done handshake, the key-schedule generator with its round-key store, and the combinational inverse-round datapath.

## Interface
- NR, 10, number of rounds; AES-128 only, not re-parameterisable
- clk  in  1  clock, all flops on rising edge
- rest  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- cipher_in  in  128  ciphertext block, sampled on the accept edge
- key_in  in  128  cipher key, sampled on the accept edge
- ks_start  out  1  one-cycle pulse starting key expansion of key_reg
- ks_key  out  128  key to expand (= key_reg)
- ks_done  in  1  expansion complete; sampled only in KWAIT
- rk_index  out  4  round-key index to the store
- rk_data  in  128  round key; valid one cycle after rk_index (registered read)
- dp_state  out  128  state register to the datapath
- dp_mode  out  2  00 = AddRoundKey only, 01 = full inverse round, 10 = final inverse round (no InvMixColumns)
- dp_result  in  128  combinational datapath result
- plain_out  out  128  plaintext; held until the next completion
- done  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, KSTART, KWAIT, FETCH, APPLY, DONE
- IDLE: on start, latch cipher_in into state_reg and set rnd = 10. If key_valid = 0 or key_in != key_reg: latch key_reg = key_in, clear key_valid, go to KSTART. Otherwise go to FETCH.
- KSTART: ks_start = 1 for exactly this cycle, then KWAIT.
- KWAIT: wait for ks_done. When it is sampled high, set key_valid = 1 and go to FETCH.
- FETCH: rk_index = rnd, then APPLY.
- APPLY: rk_data is valid. state_reg <= dp_result.
  - If rnd = 0: plain_out <= dp_result, go to DONE.
  - Else: rnd <= rnd - 1, go to FETCH.
- DONE: done = 1, then IDLE.
- dp_mode decodes from rnd: 10 gives 00, 9..1 give 01, 0 gives 10. dp_state = state_reg.
- rnd is a 4-bit down-counter. It never wraps: decrement only when rnd != 0.
- start while busy: ignored, not queued.
- ks_done outside KWAIT: ignored.
- key_in and cipher_in changes while busy: ignored.
- rest at any time, including mid-block or mid-expansion: abort to IDLE and clear key_valid. A subsequent start always re-expands.

## Timing
- Reset values: ks_start 0, ks_key 0, rk_index 0, dp_state 0, dp_mode 00 (rnd reset to 10), plain_out 0, done 0, busy 0, key_valid 0.
- Cached key, accept at edge E0:
  - FETCH/APPLY pairs for rnd 10..0 occupy edges E0..E0+21.
  - plain_out updates at edge E0+22 and done is high in the following cycle.
  - Latency = 22 cycles; busy is high 23 cycles.
- New key:
  - ks_start is high in the cycle after E0.
  - If ks_done is sampled at edge Ek, plain_out updates at Ek+22.
  - Minimum is ks_done at E0+2, giving 24 cycles.
- Next start is accepted in the cycle after done (the IDLE cycle). The minimum start-to-start period is 24 cycles with a cached key.
- rk_index is registered and changes only on FETCH entry. It holds its value in all other states.

## Structure
- Shared package aes_dec_pkg holds:
  - state encoding for IDLE..DONE (3-bit localparams)
  - dp_mode constants MODE_ARK, MODE_MID, MODE_LAST
  - NR = 10
- One sub-module, aes_key_tag, holds:
  - key_reg and key_valid
  - the 128-bit equality compare, output hit = key_valid & (key_in == key_reg)
  - a load strobe and an invalidate input driven by the FSM
- Datapath, key generator and round-key store stay outside this block.

## Test plan
- Bench models the key store and inverse round per FIPS-197. Key 000102030405060708090a0b0c0d0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a, ks_done 5 cycles after ks_start -> one ks_start pulse, plain_out = 00112233445566778899aabbccddeeff, done exactly 22 cycles after the ks_done edge.
- Same key, second block issued on the IDLE cycle after done -> no ks_start, done 22 cycles after accept, correct plaintext.
- Key changed to 2b7e151628aed2a6abf7158809cf4f3c with FIPS-197 Appendix B cipher 3925841d02dc09fbdc118597196a0b32 -> ks_start re-issued, plain_out = 3243f6a8885a308d313198a2e0370734.
- start held high throughout a block and spurious ks_done pulses in FETCH/APPLY -> exactly one block per accept, no state disturbance, rk_index sequence 10,9,...,0.
- rest asserted in APPLY at rnd = 5, then start with the previous key -> all outputs at reset values immediately, ks_start re-issued (cache cleared), correct plaintext.
- dp_mode check over one block -> 00 once, then 01 nine times, then 10 once.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared constants and types for the AES-128 decryption sequencer:
// FSM state encoding, datapath mode codes and the round count.
package aes_dec_pkg;

    localparam int NR = 10;
    localparam logic [3:0] RND_FIRST = 4'(NR);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KSTART = 3'd1,
        ST_KWAIT  = 3'd2,
        ST_FETCH  = 3'd3,
        ST_APPLY  = 3'd4,
        ST_DONE   = 3'd5
    } dec_state_e;

    localparam logic [1:0] MODE_ARK  = 2'b00;
    localparam logic [1:0] MODE_MID  = 2'b01;
    localparam logic [1:0] MODE_LAST = 2'b10;

    // Round NR is the lone initial AddRoundKey; round 0 omits InvMixColumns.
    function automatic logic [1:0] round_mode(input logic [3:0] rnd);
        if (rnd == RND_FIRST) begin
            return MODE_ARK;
        end else if (rnd == 4'd0) begin
            return MODE_LAST;
        end else begin
            return MODE_MID;
        end
    endfunction

endpackage

// File: rtl/aes_key_tag.sv
// Remembers the last cipher key handed to the key-schedule generator and
// reports whether the incoming key can reuse the already expanded schedule.
module aes_key_tag (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         invalidate_i,
    input  logic         validate_i,
    input  logic [127:0] key_in_i,
    output logic [127:0] key_o,
    output logic         hit_o
);

    logic [127:0] key_q;
    logic [127:0] key_d;
    logic         valid_q;
    logic         valid_d;

    // Invalidate wins so a reload can never be mistaken for a finished expansion.
    always_comb begin
        key_d   = key_q;
        valid_d = valid_q;
        if (load_i) begin
            key_d = key_in_i;
        end
        if (invalidate_i) begin
            valid_d = 1'b0;
        end else if (validate_i) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            key_q   <= key_d;
            valid_q <= valid_d;
        end
    end

    assign key_o = key_q;
    assign hit_o = valid_q & (key_in_i == key_q);

endmodule

// File: rtl/aes_dec_sequencer.sv
// Sequences the shared inverse-round datapath through the 11 round-key
// applications of an AES-128 block, expanding the key only when it changes.
module aes_dec_sequencer
    import aes_dec_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [127:0] cipher_in_i,
    input  logic [127:0] key_in_i,
    output logic         ks_start_o,
    output logic [127:0] ks_key_o,
    input  logic         ks_done_i,
    output logic [3:0]   rk_index_o,
    input  logic [127:0] rk_data_i,
    output logic [127:0] dp_state_o,
    output logic [1:0]   dp_mode_o,
    input  logic [127:0] dp_result_i,
    output logic [127:0] plain_out_o,
    output logic         done_o,
    output logic         busy_o
);

    dec_state_e   state_q;
    dec_state_e   state_d;
    logic [3:0]   rnd_q;
    logic [3:0]   rnd_d;
    logic [127:0] data_q;
    logic [127:0] data_d;
    logic [127:0] plain_q;
    logic [127:0] plain_d;
    logic [3:0]   rk_index_q;
    logic [3:0]   rk_index_d;

    logic         key_hit;
    logic         key_load;
    logic         key_validate;

    aes_key_tag u_key_tag (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (key_load),
        .invalidate_i (key_load),
        .validate_i   (key_validate),
        .key_in_i     (key_in_i),
        .key_o        (ks_key_o),
        .hit_o        (key_hit)
    );

    always_comb begin
        state_d      = state_q;
        rnd_d        = rnd_q;
        data_d       = data_q;
        plain_d      = plain_q;
        rk_index_d   = rk_index_q;
        key_load     = 1'b0;
        key_validate = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    data_d = cipher_in_i;
                    rnd_d  = RND_FIRST;
                    if (key_hit) begin
                        state_d = ST_FETCH;
                    end else begin
                        key_load = 1'b1;
                        state_d  = ST_KSTART;
                    end
                end
            end
            ST_KSTART: state_d = ST_KWAIT;
            ST_KWAIT: begin
                if (ks_done_i) begin
                    key_validate = 1'b1;
                    state_d      = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_APPLY;
            ST_APPLY: begin
                data_d = dp_result_i;
                if (rnd_q == 4'd0) begin
                    plain_d = dp_result_i;
                    state_d = ST_DONE;
                end else begin
                    rnd_d   = rnd_q - 4'd1;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // The store read is registered, so the index must be in place for the
        // whole FETCH cycle and stay put while APPLY consumes its data.
        if (state_d == ST_FETCH) begin
            rk_index_d = rnd_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            rnd_q      <= RND_FIRST;
            data_q     <= '0;
            plain_q    <= '0;
            rk_index_q <= '0;
        end else begin
            state_q    <= state_d;
            rnd_q      <= rnd_d;
            data_q     <= data_d;
            plain_q    <= plain_d;
            rk_index_q <= rk_index_d;
        end
    end

    assign ks_start_o  = (state_q == ST_KSTART);
    assign rk_index_o  = rk_index_q;
    assign dp_state_o  = data_q;
    assign dp_mode_o   = round_mode(rnd_q);
    assign plain_out_o = plain_q;
    assign done_o      = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);

    // rk_data_i is consumed by the external datapath, not by this block.
    logic unused_rk;
    assign unused_rk = ^rk_data_i;

endmodule
